// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
// Shared types and helpers for the serial-in/parallel-out deserializer.
//   state_e   : frame FSM states (IDLE, SHIFT, PARITY)
//   cnt_width : width of the in-frame bit counter for a given word width
// -----------------------------------------------------------------------------
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  // Bit counter only has to reach WIDTH-1; keep at least one bit so the
  // declaration stays legal for the smallest word width.
  function automatic int cnt_width(input int width);
    return ($clog2(width) < 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_deser.sv
// -----------------------------------------------------------------------------
// sipo_deser
// Assembles a WIDTH-bit word from a strobed serial bit stream, with an
// optional trailing even-parity bit. start (re)begins a frame at any time.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   single-cycle pulse that begins a new frame (aborts one
//                  in progress)
//   bit_en    in   bit strobe; sdi is sampled only on edges where it is 1
//   sdi       in   serial data bit
//   pdata     out  last completed word, held until the next load
//   load      out  one-cycle pulse in the cycle pdata updates
//   busy      out  high while a frame is being received (SHIFT or PARITY)
//   frame_err out  one-cycle pulse when start aborts a frame in progress
//   par_err   out  parity result of the last completed frame (0 = even
//                  parity holds); constant 0 when parity is disabled
// -----------------------------------------------------------------------------
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_en,
  input  logic             sdi,
  output logic [WIDTH-1:0] pdata,
  output logic             load,
  output logic             busy,
  output logic             frame_err,
  output logic             par_err
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] pdata_q;
  logic             load_q;
  logic             busy_q;
  logic             frame_err_q;
  logic             par_err_q;

  // Word as it will look once the current sdi is shifted in.
  // NOTE: combinational blocks assign every output on every path (here a
  // single unconditional assignment) so no latch is inferred.
  always_comb begin
    shreg_d = shreg_q;
    if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], sdi};
    else           shreg_d = {sdi, shreg_q[WIDTH-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      // NOTE: the shift register is plain flops (not a memory), so it is
      // reset along with everything else; no partial frame can leak out.
      shreg_q     <= '0;
      pdata_q     <= '0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      // Pulse outputs fall on the next edge regardless of inputs.
      load_q      <= 1'b0;
      frame_err_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          // sdi/bit_en are ignored here; a coincident strobe is discarded.
          if (start) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            shreg_q <= '0;
            busy_q  <= 1'b1;
          end
        end

        SHIFT: begin
          if (start) begin
            // Abort and restart; busy stays high, pdata/par_err untouched.
            frame_err_q <= 1'b1;
            cnt_q       <= '0;
            shreg_q     <= '0;
          end else if (bit_en) begin
            shreg_q <= shreg_d;
            if (cnt_q == LAST_BIT) begin
              // Clear rather than increment so the counter never wraps.
              cnt_q <= '0;
              if (PARITY_EN) begin
                state_q <= PARITY;
              end else begin
                state_q <= IDLE;
                pdata_q <= shreg_d;
                load_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        PARITY: begin
          if (start) begin
            state_q     <= SHIFT;
            frame_err_q <= 1'b1;
            cnt_q       <= '0;
            shreg_q     <= '0;
          end else if (bit_en) begin
            // Even parity: XOR over data plus parity bit must be 0.
            par_err_q <= ^{shreg_q, sdi};
            pdata_q   <= shreg_q;
            load_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign pdata     = pdata_q;
  assign load      = load_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign par_err   = PARITY_EN ? par_err_q : 1'b0;

endmodule
